// File: rtl/dram_arb_pkg.sv
// Shared types and helpers for the DRAM port arbiter.
//   arb_state_t : arbiter FSM states
//   align_addr  : clears the low block-offset bits of a word address
package dram_arb_pkg;
  localparam int CACHE_BLOCK_BITS = 512;
  localparam int BLOCK_ALIGN_BITS = 5;

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_WR, WAIT_RD, RESP} arb_state_t;

  function automatic logic [63:0] align_addr(input logic [63:0] addr, input int bits);
    return addr & ~((64'd1 << bits) - 64'd1);
  endfunction
endpackage

// File: rtl/dram_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr,
// wrapping modulo NUM_CLIENTS.
//   req : request vector       ptr : highest-priority index
//   gnt : one-hot grant        idx : grant index        any : some req set
module rr_pick #(
  parameter  int NUM_CLIENTS = 3,
  localparam int IW          = $clog2(NUM_CLIENTS)
) (
  input  logic [NUM_CLIENTS-1:0] req,
  input  logic [IW-1:0]          ptr,
  output logic [NUM_CLIENTS-1:0] gnt,
  output logic [IW-1:0]          idx,
  output logic                   any
);
  logic [IW:0] j;

  always_comb begin
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      j = {1'b0, ptr} + (IW+1)'(i);
      if (j >= (IW+1)'(NUM_CLIENTS)) j = j - (IW+1)'(NUM_CLIENTS);
      if (!any && req[j[IW-1:0]]) begin
        any = 1'b1;
        idx = j[IW-1:0];
      end
    end
    if (any) gnt[idx] = 1'b1;
  end
endmodule

// File: rtl/dram_arbiter.sv
// Round-robin arbiter sharing one cache-block DRAM port among NUM_CLIENTS
// requesters, one transaction in flight at a time.
//   cli_req/we/addr/wdata : level-held client requests (held until cli_ack)
//   cli_ack / cli_done    : one-cycle accept / completion pulses
//   cli_rdata             : last completed read block (shared)
//   mem_*                 : DRAM wrapper handshake (pulse request, held addr/data)
//   busy                  : arbiter not idle
module dram_arbiter #(
  parameter  int NUM_CLIENTS      = 3,
  parameter  int DRAM_ADDR_BITS   = 27,
  parameter  int CACHE_BLOCK_BITS = 512,
  parameter  int BLOCK_ALIGN_BITS = 5,
  localparam int IW               = $clog2(NUM_CLIENTS)
) (
  input  logic                                       sclk,
  input  logic                                       rst_n,
  input  logic [NUM_CLIENTS-1:0]                     cli_req,
  input  logic [NUM_CLIENTS-1:0]                     cli_we,
  input  logic [NUM_CLIENTS-1:0][DRAM_ADDR_BITS-1:0] cli_addr,
  input  logic [NUM_CLIENTS-1:0][CACHE_BLOCK_BITS-1:0] cli_wdata,
  output logic [NUM_CLIENTS-1:0]                     cli_ack,
  output logic [NUM_CLIENTS-1:0]                     cli_done,
  output logic [CACHE_BLOCK_BITS-1:0]                cli_rdata,
  input  logic                                       mem_calib_done,
  input  logic                                       mem_read_ready,
  input  logic                                       mem_write_ready,
  output logic                                       mem_read_request,
  output logic                                       mem_write_request,
  output logic [DRAM_ADDR_BITS-1:0]                  mem_read_address,
  output logic [DRAM_ADDR_BITS-1:0]                  mem_write_address,
  output logic [CACHE_BLOCK_BITS-1:0]                mem_write_data,
  input  logic                                       mem_read_response,
  input  logic [CACHE_BLOCK_BITS-1:0]                mem_read_data,
  output logic                                       busy
);
  import dram_arb_pkg::*;

  arb_state_t                  state, state_nx;
  logic [IW-1:0]               rr_ptr, owner, win_idx;
  logic [NUM_CLIENTS-1:0]      win_oh;
  logic                        req_any, grant, we_q;
  logic [DRAM_ADDR_BITS-1:0]   addr_q;
  logic [CACHE_BLOCK_BITS-1:0] wdata_q;

  rr_pick #(.NUM_CLIENTS(NUM_CLIENTS)) u_pick (
    .req (cli_req),
    .ptr (rr_ptr),
    .gnt (win_oh),
    .idx (win_idx),
    .any (req_any)
  );

  // Both ready flags must be high so the wrapper is fully idle before a new request.
  assign grant = (state == IDLE) && req_any && mem_calib_done &&
                 mem_read_ready && mem_write_ready;

  // Latches are the only source of the DRAM address/data, so they stay
  // stable from ISSUE through RESP.
  assign mem_read_address  = addr_q;
  assign mem_write_address = addr_q;
  assign mem_write_data    = wdata_q;

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      cli_ack   <= '0;
      cli_rdata <= '0;
    end else begin
      state   <= state_nx;
      cli_ack <= '0;
      if (grant) begin
        owner   <= win_idx;
        we_q    <= cli_we[win_idx];
        addr_q  <= DRAM_ADDR_BITS'(align_addr(64'(cli_addr[win_idx]), BLOCK_ALIGN_BITS));
        wdata_q <= cli_wdata[win_idx];
        cli_ack <= win_oh;
        rr_ptr  <= (win_idx == IW'(NUM_CLIENTS-1)) ? '0 : win_idx + 1'b1;
      end
      if (state == WAIT_RD && mem_read_response) cli_rdata <= mem_read_data;
    end
  end

  always_comb begin
    state_nx          = state;
    mem_read_request  = 1'b0;
    mem_write_request = 1'b0;
    cli_done          = '0;
    busy              = (state != IDLE);
    case (state)
      IDLE:    if (grant) state_nx = ISSUE;
      ISSUE: begin
        mem_write_request = we_q;
        mem_read_request  = !we_q;
        state_nx          = we_q ? WAIT_WR : WAIT_RD;
      end
      WAIT_WR: if (mem_write_ready)   state_nx = RESP;
      WAIT_RD: if (mem_read_response) state_nx = RESP;
      RESP: begin
        cli_done[owner] = 1'b1;
        state_nx        = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_dram_arbiter.sv
module tb_dram_arbiter;
  localparam int NC = 3, AW = 27, BW = 512;

  logic                   sclk = 1'b0;
  logic                   rst_n = 1'b0;
  logic [NC-1:0]          cli_req = '0, cli_we = '0;
  logic [NC-1:0][AW-1:0]  cli_addr = '0;
  logic [NC-1:0][BW-1:0]  cli_wdata = '0;
  logic [NC-1:0]          cli_ack, cli_done;
  logic [BW-1:0]          cli_rdata;
  logic                   mem_calib_done = 1'b0;
  logic                   mem_read_ready, mem_write_ready;
  logic                   mem_read_request, mem_write_request;
  logic [AW-1:0]          mem_read_address, mem_write_address;
  logic [BW-1:0]          mem_write_data;
  logic                   mem_read_response;
  logic [BW-1:0]          mem_read_data;
  logic                   busy;

  always #5 sclk = ~sclk;

  dram_arbiter #(.NUM_CLIENTS(NC), .DRAM_ADDR_BITS(AW), .CACHE_BLOCK_BITS(BW),
                 .BLOCK_ALIGN_BITS(5)) dut (
    .sclk(sclk), .rst_n(rst_n),
    .cli_req(cli_req), .cli_we(cli_we), .cli_addr(cli_addr), .cli_wdata(cli_wdata),
    .cli_ack(cli_ack), .cli_done(cli_done), .cli_rdata(cli_rdata),
    .mem_calib_done(mem_calib_done), .mem_read_ready(mem_read_ready),
    .mem_write_ready(mem_write_ready), .mem_read_request(mem_read_request),
    .mem_write_request(mem_write_request), .mem_read_address(mem_read_address),
    .mem_write_address(mem_write_address), .mem_write_data(mem_write_data),
    .mem_read_response(mem_read_response), .mem_read_data(mem_read_data),
    .busy(busy)
  );

  // DRAM wrapper model: fixed latencies, read data is a per-address table.
  int rd_lat = 4, wr_lat = 3;
  int cnt;
  logic mode_rd;
  logic [AW-1:0] rd_a;

  function automatic logic [BW-1:0] model_rd(input logic [AW-1:0] a);
    case (a)
      27'h100: return {16{32'h1234_5678}};
      27'h1C0: return {64{8'h3C}};
      27'h200: return {16{32'hDEAD_BEEF}};
      default: return {64{8'hEE}};
    endcase
  endfunction

  always @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 0; mode_rd <= 1'b0; rd_a <= '0;
      mem_read_response <= 1'b0; mem_read_data <= '0;
    end else begin
      mem_read_response <= 1'b0;
      if (cnt != 0) begin
        cnt <= cnt - 1;
        if (cnt == 1 && mode_rd) begin
          mem_read_response <= 1'b1;
          mem_read_data     <= model_rd(rd_a);
        end
      end else if (mem_write_request) begin
        cnt <= wr_lat; mode_rd <= 1'b0;
      end else if (mem_read_request) begin
        cnt <= rd_lat; mode_rd <= 1'b1; rd_a <= mem_read_address;
      end
    end
  end
  assign mem_read_ready  = (cnt == 0) && !mem_read_request && !mem_write_request;
  assign mem_write_ready = mem_read_ready;

  // Scoreboard
  typedef struct { int cli; logic we; logic [AW-1:0] addr; logic [BW-1:0] data; } txn_t;
  txn_t done_q[$], mem_q[$];
  int   gnt_q[$];
  int   checks = 0, errors = 0, wr_pulses = 0;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic mon_step();
    txn_t e;
    if (!rst_n) return;
    if (cli_ack != '0) chk($onehot(cli_ack), "ack_onehot", 64'(cli_ack), 64'(0));
    if (cli_done != '0) begin
      if (done_q.size() == 0) chk(1'b0, "done_unexpected", 64'(cli_done), 64'(0));
      else begin
        e = done_q.pop_front();
        chk(cli_done == (NC'(1) << e.cli), "done_owner", 64'(cli_done), 64'(NC'(1) << e.cli));
        if (!e.we) chk(cli_rdata == e.data, "done_rdata", cli_rdata[63:0], e.data[63:0]);
      end
    end
    if (mem_read_request && mem_write_request) chk(1'b0, "req_both", 64'd3, 64'd0);
    else if (mem_read_request || mem_write_request) begin
      if (mem_write_request) wr_pulses++;
      if (mem_q.size() == 0) chk(1'b0, "mem_unexpected", 64'(mem_write_request), 64'd0);
      else begin
        e = mem_q.pop_front();
        chk(mem_write_request == e.we, "mem_dir", 64'(mem_write_request), 64'(e.we));
        chk((e.we ? mem_write_address : mem_read_address) == e.addr, "mem_addr",
            64'(e.we ? mem_write_address : mem_read_address), 64'(e.addr));
        if (e.we) chk(mem_write_data == e.data, "mem_wdata", mem_write_data[63:0], e.data[63:0]);
      end
    end
  endtask

  // Program client c; expect: aligned address a_al, d = wdata (write) or read block.
  task automatic setup(input int c, input logic we, input logic [AW-1:0] a,
                       input logic [AW-1:0] a_al, input logic [BW-1:0] d, input bit exp_done);
    txn_t e;
    cli_we[c] = we; cli_addr[c] = a; cli_wdata[c] = we ? d : {64{8'hC3}};
    e.cli = c; e.we = we; e.addr = a_al; e.data = d;
    mem_q.push_back(e);
    if (exp_done) done_q.push_back(e);
  endtask

  task automatic wait_ack(input int c);
    int n = 0;
    do begin @(negedge sclk); n++; end while (!cli_ack[c] && n < 100);
    chk(cli_ack == (NC'(1) << c), "ack", 64'(cli_ack), 64'(NC'(1) << c));
    cli_req[c] = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    do begin @(negedge sclk); n++; end while ((busy || done_q.size() != 0) && n < 300);
    chk(!busy && done_q.size() == 0, name, 64'(done_q.size()), 64'd0);
  endtask

  task automatic burst(input logic [NC-1:0] mask, input int ngr, input bit hold);
    int n, exp;
    cli_req = mask;
    for (int k = 0; k < ngr; k++) begin
      n = 0;
      do begin @(negedge sclk); n++; end while (cli_ack == '0 && n < 100);
      exp = (gnt_q.size() != 0) ? gnt_q.pop_front() : 0;
      chk(cli_ack == (NC'(1) << exp), "gnt_order", 64'(cli_ack), 64'(NC'(1) << exp));
      if (!hold) cli_req = cli_req & ~cli_ack;
    end
    cli_req = '0;
  endtask

  initial begin
    bit seen;
    int n;
    fork
      forever begin @(negedge sclk); mon_step(); end
    join_none

    // reset state
    repeat (3) @(negedge sclk);
    chk(cli_ack == 0 && cli_done == 0 && !busy, "reset_ctl", {cli_ack, cli_done, busy}, 64'd0);
    chk(!mem_read_request && !mem_write_request && mem_write_address == 0 && mem_read_address == 0,
        "reset_mem", 64'(mem_write_address), 64'd0);
    chk(cli_rdata == '0 && mem_write_data == '0, "reset_data", cli_rdata[63:0], 64'd0);
    rst_n = 1'b1;

    // calibration gate: client0 write held while calib low
    setup(0, 1'b1, 27'h300, 27'h300, {64{8'h5A}}, 1'b1);
    cli_req[0] = 1'b1;
    seen = 1'b0;
    repeat (20) begin @(negedge sclk); if (cli_ack != '0 || busy) seen = 1'b1; end
    chk(!seen, "calib_gate", 64'(seen), 64'd0);
    mem_calib_done = 1'b1;
    n = 0;
    do begin @(negedge sclk); n++; end while (!cli_ack[0] && n < 2);
    chk(cli_ack == 3'b001, "calib_ack", 64'(cli_ack), 64'd1);
    cli_req[0] = 1'b0;
    wait_idle("calib_done");

    // single write from client1, unaligned address
    wr_pulses = 0;
    setup(1, 1'b1, 27'h04A, 27'h040, {64{8'hA5}}, 1'b1);
    cli_req[1] = 1'b1;
    wait_ack(1);
    wait_idle("wr_done");
    chk(wr_pulses == 1, "wr_pulse_count", 64'(wr_pulses), 64'd1);

    // wrap fairness: rr_ptr=2, clients 0 and 2 -> 2 then 0
    setup(2, 1'b0, 27'h1C5, 27'h1C0, {64{8'h3C}}, 1'b1);
    setup(0, 1'b1, 27'h0E0, 27'h0E0, {64{8'h0F}}, 1'b1);
    gnt_q = '{2, 0};
    burst(3'b101, 2, 1'b0);
    wait_idle("wrap_done");

    // single read client0, then a write must not disturb cli_rdata
    setup(0, 1'b0, 27'h100, 27'h100, {16{32'h1234_5678}}, 1'b1);
    cli_req[0] = 1'b1;
    wait_ack(0);
    wait_idle("rd_done");
    setup(2, 1'b1, 27'h080, 27'h080, {64{8'h77}}, 1'b1);
    cli_req[2] = 1'b1;
    wait_ack(2);
    wait_idle("wr2_done");
    chk(cli_rdata == {16{32'h1234_5678}}, "rdata_hold", cli_rdata[63:0], 64'h1234_5678_1234_5678);

    // contention: all three held continuously for six grants
    for (int r = 0; r < 2; r++) begin
      setup(0, 1'b0, 27'h100, 27'h100, {16{32'h1234_5678}}, 1'b1);
      setup(1, 1'b1, 27'h060, 27'h060, {64{8'h11}}, 1'b1);
      setup(2, 1'b0, 27'h1C0, 27'h1C0, {64{8'h3C}}, 1'b1);
    end
    gnt_q = '{0, 1, 2, 0, 1, 2};
    burst(3'b111, 6, 1'b1);
    wait_idle("cont_done");

    // async reset while in WAIT_RD, with client1 pending
    rd_lat = 30;
    setup(0, 1'b0, 27'h200, 27'h200, {16{32'hDEAD_BEEF}}, 1'b0);
    cli_req[0] = 1'b1;
    wait_ack(0);
    setup(1, 1'b1, 27'h120, 27'h120, {64{8'h99}}, 1'b1);
    cli_req[1] = 1'b1;
    repeat (5) @(negedge sclk);
    chk(busy == 1'b1, "wait_rd_busy", 64'(busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk(cli_ack == 0 && cli_done == 0 && !busy && !mem_read_request && !mem_write_request,
        "rst_async_ctl", {cli_ack, cli_done, busy}, 64'd0);
    chk(mem_read_address == 0 && mem_write_data == '0 && cli_rdata == '0, "rst_async_data",
        64'(mem_read_address), 64'd0);
    rd_lat = 4;
    repeat (2) @(negedge sclk);
    rst_n = 1'b1;
    wait_ack(1);
    wait_idle("post_rst_done");

    chk(done_q.size() == 0, "done_q_empty", 64'(done_q.size()), 64'd0);
    chk(mem_q.size() == 0, "mem_q_empty", 64'(mem_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
